// File: rtl/axis_in_pack_pkg.sv
// Shared definitions for the narrow-to-wide AXI-stream packer.
// Optional feature macro: AXIS_IN_PACK_KEEP_EN (keep/last sideband on the output).
package axis_in_pack_pkg;

  localparam int DEF_IN_DATA_W  = 8;
  localparam int DEF_OUT_DATA_W = 32;
  localparam int MAX_LANES      = 64;

  // Keep mask for a word whose highest written lane is 'lane': bits [lane:0] set.
  function automatic logic [MAX_LANES-1:0] lane_mask_f(input int unsigned lane);
    lane_mask_f = (64'd2 << lane) - 64'd1;
  endfunction

endpackage

// File: rtl/axis_in_pack_lane_ctr.sv
// Lane counter for the packer: points at the next lane of the word to fill.
// Clear has priority over increment; wrap back to 0 happens only via clear.
module axis_in_pack_lane_ctr
  import axis_in_pack_pkg::*;
#(
  parameter int LANE_W = 2
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [LANE_W-1:0] cnt_o
);

  logic [LANE_W-1:0] r_cnt;

  // Lane count register: reset/clear to lane 0, step on a non-final accepted beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= {LANE_W{1'b0}};
    end else if (cke_i) begin
      if (clr_i) begin
        r_cnt <= {LANE_W{1'b0}};
      end else if (inc_i) begin
        r_cnt <= r_cnt + {{(LANE_W-1){1'b0}}, 1'b1};
      end else begin
        r_cnt <= r_cnt;
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/axis_in_pack.sv
// Packs a narrow AXI-stream into full-width little-endian words. A beat with
// last set flushes the partial word zero-padded in the unwritten upper lanes.
// Optional feature macro: AXIS_IN_PACK_KEEP_EN adds axis_out_keep_o / axis_out_last_o.
module axis_in_pack
  import axis_in_pack_pkg::*;
#(
  parameter int IN_DATA_W  = DEF_IN_DATA_W,
  parameter int OUT_DATA_W = DEF_OUT_DATA_W
) (
  input  logic                            clk_i,
  input  logic                            cke_i,
  input  logic                            rst_i,
  input  logic [IN_DATA_W-1:0]            axis_in_data_i,
  input  logic                            axis_in_valid_i,
  input  logic                            axis_in_last_i,
  output logic                            axis_in_ready_o,
  output logic [OUT_DATA_W-1:0]           axis_out_data_o,
  output logic                            axis_out_valid_o,
`ifdef AXIS_IN_PACK_KEEP_EN
  output logic [OUT_DATA_W/IN_DATA_W-1:0] axis_out_keep_o,
  output logic                            axis_out_last_o,
`endif
  input  logic                            axis_out_ready_i
);

  localparam int R      = OUT_DATA_W / IN_DATA_W;
  localparam int LANE_W = $clog2(R);

  logic [LANE_W-1:0]     w_lane;
  logic                  w_out_stall;
  logic                  w_accept;
  logic                  w_complete;
  logic [OUT_DATA_W-1:0] w_word;
  logic [OUT_DATA_W-1:0] r_acc;
  logic [OUT_DATA_W-1:0] r_out_data;
  logic                  r_out_valid;

  // A pending word that downstream refuses blocks the input; cke low blocks everything.
  assign w_out_stall     = r_out_valid & ~axis_out_ready_i;
  assign axis_in_ready_o = cke_i & ~w_out_stall;
  assign w_accept        = axis_in_valid_i & axis_in_ready_o;
  assign w_complete      = w_accept & ((w_lane == LANE_W'(R - 1)) | axis_in_last_i);

  axis_in_pack_lane_ctr #(
    .LANE_W (LANE_W)
  ) u_lane_ctr (
    .clk_i  (clk_i),
    .cke_i  (cke_i),
    .rst_i  (rst_i),
    .clr_i  (w_complete),
    .inc_i  (w_accept & ~w_complete),
    .cnt_o  (w_lane)
  );

  // Merge the incoming beat into its lane; lanes above it are still zero in r_acc.
  always_comb begin
    w_word = r_acc;
    for (int i = 0; i < R; i++) begin
      w_word[i*IN_DATA_W +: IN_DATA_W] = (w_lane == LANE_W'(i)) ? axis_in_data_i
                                                                 : r_acc[i*IN_DATA_W +: IN_DATA_W];
    end
  end

  // Accumulator: collects lanes of the word in progress, emptied when the word completes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc <= {OUT_DATA_W{1'b0}};
    end else if (cke_i) begin
      if (w_complete) begin
        r_acc <= {OUT_DATA_W{1'b0}};
      end else if (w_accept) begin
        r_acc <= w_word;
      end else begin
        r_acc <= r_acc;
      end
    end else begin
      r_acc <= r_acc;
    end
  end

  // Output word register: load on completion (even while the old word drains), else drop valid on handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out_data  <= {OUT_DATA_W{1'b0}};
      r_out_valid <= 1'b0;
    end else if (cke_i) begin
      if (w_complete) begin
        r_out_data  <= w_word;
        r_out_valid <= 1'b1;
      end else if (r_out_valid & axis_out_ready_i) begin
        r_out_data  <= r_out_data;
        r_out_valid <= 1'b0;
      end else begin
        r_out_data  <= r_out_data;
        r_out_valid <= r_out_valid;
      end
    end else begin
      r_out_data  <= r_out_data;
      r_out_valid <= r_out_valid;
    end
  end

  assign axis_out_data_o  = r_out_data;
  assign axis_out_valid_o = r_out_valid;

`ifdef AXIS_IN_PACK_KEEP_EN
  logic [MAX_LANES-1:0] w_mask_full;
  logic [R-1:0]         r_keep;
  logic                 r_last;

  assign w_mask_full = lane_mask_f(int'(w_lane));

  // Sideband register: lanes written and packet-close flag travel with the data word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_keep <= {R{1'b0}};
      r_last <= 1'b0;
    end else if (cke_i) begin
      if (w_complete) begin
        r_keep <= w_mask_full[R-1:0];
        r_last <= axis_in_last_i;
      end else begin
        r_keep <= r_keep;
        r_last <= r_last;
      end
    end else begin
      r_keep <= r_keep;
      r_last <= r_last;
    end
  end

  assign axis_out_keep_o = r_keep;
  assign axis_out_last_o = r_last;
`endif

endmodule

// File: tb/tb_axis_in_pack.sv
// Directed bench for axis_in_pack (8-bit in, 32-bit out). Keep/last checks are
// compiled in when AXIS_IN_PACK_KEEP_EN is defined.
module tb_axis_in_pack;

  logic        clk;
  logic        cke;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
`ifdef AXIS_IN_PACK_KEEP_EN
  logic [3:0]  out_keep;
  logic        out_last;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  axis_in_pack #(
    .IN_DATA_W  (8),
    .OUT_DATA_W (32)
  ) dut (
    .clk_i            (clk),
    .cke_i            (cke),
    .rst_i            (rst),
    .axis_in_data_i   (in_data),
    .axis_in_valid_i  (in_valid),
    .axis_in_last_i   (in_last),
    .axis_in_ready_o  (in_ready),
    .axis_out_data_o  (out_data),
    .axis_out_valid_o (out_valid),
`ifdef AXIS_IN_PACK_KEEP_EN
    .axis_out_keep_o  (out_keep),
    .axis_out_last_o  (out_last),
`endif
    .axis_out_ready_i (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every word downstream takes (handshake completes at the following rising edge).
  always @(negedge clk) begin
    if (!rst && cke && out_valid && out_ready) got_q.push_back(out_data);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l);
    int  n;
    logic taken;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = l;
    n        = 0;
    do begin
      @(negedge clk);
      taken = in_ready & in_valid;
      @(posedge clk);
      #1;
      n++;
    end while (!taken && n < 50);
    if (!taken) check("beat_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain_check(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_word"}, 64'(got_q[i]), 64'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int drops;
    int vcnt;
    int bad;
    int last_idx;

    cke       = 1'b1;
    rst       = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data",  64'(out_data),  64'd0);
    check("rst_ready", 64'(in_ready),  64'd1);
    @(posedge clk);
    #1;

    // 1: full word, back-to-back
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b0);
    check("t1_no_early_valid", 64'(out_valid), 64'd0);
    send_beat(8'h44, 1'b0);
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_data",  64'(out_data),  64'h44332211);
`ifdef AXIS_IN_PACK_KEEP_EN
    check("t1_keep", 64'(out_keep), 64'hF);
    check("t1_last", 64'(out_last), 64'd0);
`endif
    exp_q.push_back(32'h44332211);
    drain_check("t1");

    // 2: two-beat packet flushed by last
    send_beat(8'hA1, 1'b0);
    send_beat(8'hB2, 1'b1);
    check("t2_data", 64'(out_data), 64'h0000B2A1);
`ifdef AXIS_IN_PACK_KEEP_EN
    check("t2_keep", 64'(out_keep), 64'h3);
    check("t2_last", 64'(out_last), 64'd1);
`endif
    exp_q.push_back(32'h0000B2A1);
    drain_check("t2");

    // 3: downstream backpressure with a pending word
    out_ready = 1'b0;
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b0);
    send_beat(8'h44, 1'b0);
    in_data  = 8'h55;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_stall_ready", 64'(in_ready),  64'd0);
      check("t3_hold_valid",  64'(out_valid), 64'd1);
      check("t3_hold_data",   64'(out_data),  64'h44332211);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send_beat(8'h55, 1'b0);
    send_beat(8'h66, 1'b0);
    send_beat(8'h77, 1'b0);
    send_beat(8'h88, 1'b0);
    send_beat(8'h99, 1'b1);
    exp_q.push_back(32'h44332211);
    exp_q.push_back(32'h88776655);
    exp_q.push_back(32'h00000099);
    drain_check("t3");

    // 4: continuous 64-beat stream
    drops    = 0;
    vcnt     = 0;
    bad      = 0;
    last_idx = -1;
    for (int i = 0; i <= 64; i++) begin
      in_data  = 8'(i);
      in_valid = (i < 64);
      @(negedge clk);
      if (i < 64 && !in_ready) drops++;
      if (out_valid) begin
        if (last_idx >= 0 && (i - last_idx) != 4) bad++;
        last_idx = i;
        vcnt++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("t4_ready_drops", 64'(drops), 64'd0);
    check("t4_valid_count", 64'(vcnt),  64'd16);
    check("t4_valid_gap",   64'(bad),   64'd0);
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
    end
    drain_check("t4");

    // 5: reset mid-word discards the partial word
    send_beat(8'hAA, 1'b0);
    send_beat(8'hBB, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_valid_after_rst", 64'(out_valid), 64'd0);
    send_beat(8'h01, 1'b0);
    send_beat(8'h02, 1'b0);
    send_beat(8'h03, 1'b0);
    send_beat(8'h04, 1'b0);
    exp_q.push_back(32'h04030201);
    drain_check("t5");

    // 6: single-beat packet, then clock-enable gap mid-word
    send_beat(8'h7E, 1'b1);
    check("t6_single", 64'(out_data), 64'h0000007E);
`ifdef AXIS_IN_PACK_KEEP_EN
    check("t6_keep", 64'(out_keep), 64'h1);
    check("t6_last", 64'(out_last), 64'd1);
`endif
    exp_q.push_back(32'h0000007E);
    drain_check("t6a");
    send_beat(8'h10, 1'b0);
    send_beat(8'h20, 1'b0);
    in_data  = 8'h30;
    in_valid = 1'b1;
    cke      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_cke_ready", 64'(in_ready),  64'd0);
      check("t6_cke_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    cke = 1'b1;
    send_beat(8'h30, 1'b0);
    send_beat(8'h40, 1'b0);
    check("t6_cke_word", 64'(out_data), 64'h40302010);
    exp_q.push_back(32'h40302010);
    drain_check("t6b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
